// File: rtl/pw_pkg.sv
// pw_pkg: shared state encoding, digit geometry and digit-insert helper for the password checker.
package pw_pkg;

   localparam int DIGIT_W    = 4;
   localparam int NUM_DIGITS = 4;
   localparam int CODE_W     = DIGIT_W * NUM_DIGITS;

   typedef enum logic [2:0] {
      ENTRY,
      CHECK,
      OPEN,
      FAIL_SHOW,
      LOCKOUT,
      PROGRAM
   } state_t;

   // Digit 0 sits in the most significant nibble, matching how the code is read left to right.
   function automatic logic [CODE_W-1:0] put_digit(
      input logic [CODE_W-1:0]  code,
      input logic [1:0]         idx,
      input logic [DIGIT_W-1:0] d
   );
      logic [CODE_W-1:0] r;
      r = code;
      r[(NUM_DIGITS - 1 - int'(idx)) * DIGIT_W +: DIGIT_W] = d;
      return r;
   endfunction

endpackage

// File: rtl/rise_edge_det.sv
// rise_edge_det: one-cycle pulse on a rising level; the level held through reset is absorbed.
module rise_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   // Tracking the live level during reset means a button held across reset never reads as a press.
   always_ff @(posedge clk) d_q <= d_i;

   assign rise_o = d_i & ~d_q & ~rst;

endmodule

// File: rtl/password_check_fsm.sv
// password_check_fsm: four-digit code entry with unlock, fail display and lockout.
// Define PW_CHANGE_EN to add set_pw and a programmable password register.
module password_check_fsm
   import pw_pkg::*;
#(
   parameter logic [15:0] PASSWORD       = 16'h1234,
   parameter int          MAX_FAIL       = 3,
   parameter int          SHOW_CYCLES    = 4,
   parameter int          LOCKOUT_CYCLES = 16
) (
   input  logic       new_clk,
   input  logic       rst,
   input  logic [3:0] switch_test,
   input  logic       clean_enter,
`ifdef PW_CHANGE_EN
   input  logic       set_pw,
`endif
   output logic [1:0] digit_idx,
   output logic       unlocked,
   output logic       fail,
   output logic       locked_out,
   output logic [3:0] fail_count
);

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [CODE_W-1:0] entry_q, entry_d;
   logic [15:0]       timer_q, timer_d;
   logic [3:0]        fc_q, fc_d;
   logic              unlocked_q, fail_q, locked_q;
   logic [CODE_W-1:0] pw;
   logic              enter_edge;

`ifdef PW_CHANGE_EN
   logic [CODE_W-1:0] pw_q, pw_d;
   assign pw = pw_q;
`else
   assign pw = PASSWORD;
`endif

   rise_edge_det u_enter (
      .clk    (new_clk),
      .rst    (rst),
      .d_i    (clean_enter),
      .rise_o (enter_edge)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      entry_d = entry_q;
      timer_d = timer_q;
      fc_d    = fc_q;
`ifdef PW_CHANGE_EN
      pw_d    = pw_q;
`endif
      unique case (state_q)
         ENTRY, PROGRAM: begin
            if (enter_edge) begin
               entry_d = put_digit(entry_q, idx_q, switch_test);
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'(NUM_DIGITS - 1)) begin
                  state_d = (state_q == PROGRAM) ? ENTRY : CHECK;
`ifdef PW_CHANGE_EN
                  if (state_q == PROGRAM) begin
                     pw_d    = entry_d;
                     entry_d = '0;
                  end
`endif
               end
            end
         end
         CHECK: begin
            if (entry_q == pw) begin
               state_d = OPEN;
               fc_d    = '0;
            end else if (({1'b0, fc_q} + 5'd1) == 5'(MAX_FAIL)) begin
               state_d = LOCKOUT;
               timer_d = 16'(LOCKOUT_CYCLES - 1);
               fc_d    = 4'(MAX_FAIL);
            end else begin
               state_d = FAIL_SHOW;
               timer_d = 16'(SHOW_CYCLES - 1);
               fc_d    = (fc_q == 4'hF) ? fc_q : fc_q + 4'd1;
            end
         end
         OPEN: begin
            if (enter_edge) begin
`ifdef PW_CHANGE_EN
               state_d = set_pw ? PROGRAM : ENTRY;
`else
               state_d = ENTRY;
`endif
               entry_d = '0;
               idx_d   = '0;
            end
         end
         FAIL_SHOW: begin
            state_d = (timer_q == '0) ? ENTRY : FAIL_SHOW;
            timer_d = (timer_q == '0) ? '0 : timer_q - 16'd1;
         end
         LOCKOUT: begin
            state_d = (timer_q == '0) ? ENTRY : LOCKOUT;
            timer_d = (timer_q == '0) ? '0 : timer_q - 16'd1;
            fc_d    = (timer_q == '0) ? '0 : fc_q;
         end
         default: state_d = ENTRY;
      endcase
   end

   // Indications are registered from the current state, so they trail the state by one cycle.
   always_ff @(posedge new_clk) begin
      if (rst) begin
         state_q    <= ENTRY;
         idx_q      <= '0;
         entry_q    <= '0;
         timer_q    <= '0;
         fc_q       <= '0;
         unlocked_q <= 1'b0;
         fail_q     <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         entry_q    <= entry_d;
         timer_q    <= timer_d;
         fc_q       <= fc_d;
         unlocked_q <= (state_q == OPEN);
         fail_q     <= (state_q == FAIL_SHOW);
         locked_q   <= (state_q == LOCKOUT);
      end
   end

`ifdef PW_CHANGE_EN
   always_ff @(posedge new_clk) pw_q <= rst ? PASSWORD : pw_d;
`endif

   assign digit_idx  = idx_q;
   assign unlocked   = unlocked_q;
   assign fail       = fail_q;
   assign locked_out = locked_q;
   assign fail_count = fc_q;

endmodule

// File: tb/tb_password_check_fsm.sv
// tb_password_check_fsm: scoreboard bench; indication events are queued at the 4th digit and matched on rise.
module tb_password_check_fsm;

   typedef struct {
      int flags;
      int fc;
      int at;
      int len;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] switch_test = '0;
   logic       clean_enter = 1'b0;
   logic       set_pw = 1'b0;
   logic [1:0] digit_idx;
   logic       unlocked, fail, locked_out;
   logic [3:0] fail_count;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   press_cyc = 0;
   exp_t sb[$];
   exp_t act;
   logic [2:0] prev = '0;
   logic [2:0] cur;
   int   start = 0;
   bit   busy = 1'b0;

   localparam int UNL = 4, FL = 2, LK = 1;

   password_check_fsm dut (
      .new_clk     (clk),
      .rst         (rst),
      .switch_test (switch_test),
      .clean_enter (clean_enter),
`ifdef PW_CHANGE_EN
      .set_pw      (set_pw),
`endif
      .digit_idx   (digit_idx),
      .unlocked    (unlocked),
      .fail        (fail),
      .locked_out  (locked_out),
      .fail_count  (fail_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Indication monitor: pops one expectation per rising indication and times the pulse.
   always @(negedge clk) begin
      cur = {unlocked, fail, locked_out};
      if (rst) begin
         busy = 1'b0;
      end else if (prev == 3'b0 && cur != 3'b0) begin
         if (sb.size() == 0) check("unexpected_ind", int'(cur), 0);
         else begin
            act = sb.pop_front();
            check("ind_flags", int'(cur), act.flags);
            check("ind_fail_count", int'(fail_count), act.fc);
            check("ind_latency", cyc, act.at);
            start = cyc;
            busy  = (act.len != 0);
         end
      end else if (prev != 3'b0 && cur == 3'b0 && busy) begin
         check("ind_len", cyc - start, act.len);
         busy = 1'b0;
      end
      prev = cur;
   end

   task automatic press(input logic [3:0] d, input int exp_idx);
      @(negedge clk);
      switch_test = d;
      clean_enter = 1'b1;
      press_cyc   = cyc;
      @(negedge clk);
      clean_enter = 1'b0;
      check("digit_idx", int'(digit_idx), exp_idx);
   endtask

   task automatic enter_code(input logic [15:0] code, input int flags, input int fc, input int len);
      for (int i = 0; i < 4; i++) press(code[15-4*i -: 4], (i + 1) % 4);
      if (flags != 0) sb.push_back('{flags: flags, fc: fc, at: press_cyc + 3, len: len});
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 64) begin
         @(negedge clk);
         n++;
      end
      check("wait_done", int'(n < 64), 1);
   endtask

   task automatic relock();
      press(4'h0, 0);
      @(negedge clk);
      check("relock_unlocked", int'(unlocked), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_idx", int'(digit_idx), 0);
      check("rst_ind", int'({unlocked, fail, locked_out}), 0);
      check("rst_fc", int'(fail_count), 0);
      enter_code(16'h1234, UNL, 0, 0);
      wait_done();
      relock();
      enter_code(16'h1234, UNL, 0, 0);
      wait_done();
      relock();
      enter_code(16'h1235, FL, 1, 4);
      press(4'h1, 0);
      wait_done();
      check("after_fail_idx", int'(digit_idx), 0);
      enter_code(16'h1234, UNL, 0, 0);
      wait_done();
      relock();
      enter_code(16'h0000, FL, 1, 4);
      wait_done();
      enter_code(16'h4321, FL, 2, 4);
      wait_done();
      enter_code(16'h1239, LK, 3, 16);
      press(4'h5, 0);
      wait_done();
      check("after_lock_fc", int'(fail_count), 0);
      enter_code(16'h1234, UNL, 0, 0);
      wait_done();
      relock();
      @(negedge clk);
      rst = 1'b1;
      clean_enter = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("held_enter_idx", int'(digit_idx), 0);
      clean_enter = 1'b0;
      press(4'h1, 1);
      press(4'h2, 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_idx", int'(digit_idx), 0);
      check("midrst_ind", int'({unlocked, fail, locked_out}), 0);
      check("midrst_fc", int'(fail_count), 0);
      enter_code(16'h1234, UNL, 0, 0);
      wait_done();
`ifdef PW_CHANGE_EN
      @(negedge clk);
      set_pw = 1'b1;
      press(4'h0, 0);
      set_pw = 1'b0;
      enter_code(16'h9876, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("prog_unlocked", int'(unlocked), 0);
      enter_code(16'h1234, FL, 1, 4);
      wait_done();
      enter_code(16'h9876, UNL, 0, 0);
      wait_done();
`endif
      repeat (4) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
